// File: rtl/ssrv_bus_pkg.sv
// ssrv_bus_pkg
//   Shared definitions for the data-memory Wishbone bridge:
//   - dmem access width codes (byte / halfword / word / reserved)
//   - the bridge FSM state encoding
package ssrv_bus_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } bridge_state_e;

endpackage

// File: rtl/ssrv_lane_align.sv
// ssrv_lane_align
//   Purely combinational byte-lane logic for the dmem bridge.
//   Ports:
//     width_i      access width code (ssrv_bus_pkg WIDTH_*)
//     offset_i     byte offset inside the word (addr[1:0])
//     wdata_i      right-justified store data from the core
//     bus_rdata_i  raw 32-bit word from the bus
//     sel_o        Wishbone byte-lane select
//     wdat_o       store data replicated across all lanes of its size
//     rdata_o      load data shifted down to bit 0, upper bits zero
//     legal_o      1 when width is defined and the address is naturally aligned
module ssrv_lane_align
  import ssrv_bus_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic [31:0] rdata_o,
  output logic        legal_o
);

  logic [31:0] shifted_s;

  // Addressed lane moved down to bit 0 (shift by 8 * offset).
  assign shifted_s = bus_rdata_i >> {offset_i, 3'b000};

  // Lane select, write replication, read masking and legality per width.
  always_comb begin
    sel_o   = 4'b0000;
    wdat_o  = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    legal_o = 1'b0;
    case (width_i)
      WIDTH_BYTE: begin
        sel_o   = 4'b0001 << offset_i;
        wdat_o  = {4{wdata_i[7:0]}};
        rdata_o = {24'h00_0000, shifted_s[7:0]};
        legal_o = 1'b1;
      end
      WIDTH_HALF: begin
        sel_o   = 4'b0011 << offset_i;
        wdat_o  = {2{wdata_i[15:0]}};
        rdata_o = {16'h0000, shifted_s[15:0]};
        legal_o = ~offset_i[0];
      end
      WIDTH_WORD: begin
        sel_o   = 4'b1111;
        wdat_o  = wdata_i;
        rdata_o = shifted_s;
        legal_o = (offset_i == 2'b00);
      end
      default: begin
        // Reserved width: nothing selected, request rejected.
        sel_o   = 4'b0000;
        wdat_o  = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ssrv_dmem_wb_bridge.sv
// ssrv_dmem_wb_bridge
//   Bridges the core's dmem request/response port onto a single-master
//   Wishbone classic bus. Illegal requests (reserved width, misaligned
//   halfword/word) are answered with err without touching the bus; a bus
//   cycle that sees no ack within TIMEOUT_CYCLES is aborted with err.
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     dmem_req/cmd/width/addr/wdata   core request (held stable until resp)
//     dmem_rdata/resp/err      one-cycle response to the core
//     wb_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o   Wishbone master outputs
//     wb_dat_i/ack_i           Wishbone slave response
//   All outputs come straight from flops.
module ssrv_dmem_wb_bridge
  import ssrv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  // Count value reached in the last permitted BUS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e state_q;
  logic          cyc_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   wdat_q;
  logic [31:0]   rdata_q;
  logic          resp_q;
  logic          err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0]    lane_sel_s;
  logic [31:0]   lane_wdat_s;
  logic [31:0]   lane_rdata_s;
  logic          lane_legal_s;
  logic          timeout_s;

  // Request width/offset stay valid through BUS because the core holds them.
  ssrv_lane_align u_lane_align (
    .width_i     (dmem_width),
    .offset_i    (dmem_addr[1:0]),
    .wdata_i     (dmem_wdata),
    .bus_rdata_i (wb_dat_i),
    .sel_o       (lane_sel_s),
    .wdat_o      (lane_wdat_s),
    .rdata_o     (lane_rdata_s),
    .legal_o     (lane_legal_s)
  );

  assign cnt_d     = cnt_q + CNT_W'(1);
  assign timeout_s = TO_EN && (cnt_q == CNT_LAST);

  // Bridge FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0000_0000;
      sel_q   <= 4'b0000;
      wdat_q  <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0000_0000;
          cnt_q   <= '0;
          if (dmem_req) begin
            if (lane_legal_s) begin
              we_q    <= dmem_cmd;
              adr_q   <= {dmem_addr[31:2], 2'b00};
              sel_q   <= lane_sel_s;
              wdat_q  <= lane_wdat_s;
              cyc_q   <= 1'b1;
              state_q <= ST_BUS;
            end else begin
              // Rejected without a bus cycle.
              resp_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            // Ack has priority over a timeout in the same cycle.
            cyc_q   <= 1'b0;
            resp_q  <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0000_0000 : lane_rdata_s;
            state_q <= ST_RESP;
          end else if (timeout_s) begin
            cyc_q   <= 1'b0;
            resp_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 32'h0000_0000;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          // Single-cycle response; dmem_req is not looked at here.
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0000_0000;
          state_q <= ST_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0000_0000;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = sel_q;
  assign wb_dat_o   = wdat_q;
  assign dmem_rdata = rdata_q;
  assign dmem_resp  = resp_q;
  assign dmem_err   = err_q;

endmodule

// File: tb/tb_ssrv_dmem_wb_bridge.sv
// tb_ssrv_dmem_wb_bridge
//   Directed bench for the dmem -> Wishbone bridge. A transaction-level model
//   (access size, lane arithmetic, expected latency) supplies the expected
//   values; one negedge process compares bus and response outputs against it.
module tb_ssrv_dmem_wb_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_req = 1'b0;
  logic        dmem_cmd = 1'b0;
  logic [1:0]  dmem_width = 2'b00;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the transaction currently presented by the core.
  logic        cur_cmd = 1'b0;
  logic [1:0]  cur_width = 2'b00;
  logic [31:0] cur_addr = 32'h0;
  logic [31:0] cur_wdata = 32'h0;
  logic [31:0] cur_rd = 32'h0;
  logic        cur_err = 1'b0;
  logic        active = 1'b0;

  // Last values seen on the bus / response, for literal pins.
  logic [31:0] snap_adr = 32'h0;
  logic [31:0] snap_dat = 32'h0;
  logic [3:0]  snap_sel = 4'h0;
  logic        snap_we = 1'b0;
  logic [31:0] snap_rdata = 32'h0;
  logic        snap_err = 1'b0;

  ssrv_dmem_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_req   (dmem_req),
    .dmem_cmd   (dmem_cmd),
    .dmem_width (dmem_width),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .dmem_err   (dmem_err),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Access size in bytes; 0 for the reserved code.
  function automatic int size_of(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [1:0] w, input logic [31:0] a);
    int s;
    s = size_of(w);
    if (s == 0) return 1'b0;
    return (int'(a[1:0]) % s) == 0;
  endfunction

  // Lane i is selected when it falls inside [offset, offset+size).
  function automatic logic [3:0] m_sel(input logic [1:0] w, input logic [31:0] a);
    logic [3:0] s;
    int o;
    o = int'(a[1:0]);
    s = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= o) && (i < o + size_of(w));
    return s;
  endfunction

  function automatic logic [31:0] m_dat(input logic [1:0] w, input logic [31:0] wd);
    case (size_of(w))
      1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    longint v;
    longint mask;
    v = longint'(d) >> (8 * int'(a[1:0]));
    mask = (longint'(1) << (8 * size_of(w))) - 1;
    return 32'(v & mask);
  endfunction

  // Compare process: bus outputs while cyc is up, response while resp is up.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
      if (wb_cyc_o) begin
        snap_adr = wb_adr_o;
        snap_dat = wb_dat_o;
        snap_sel = wb_sel_o;
        snap_we  = wb_we_o;
        chk("cyc_expected", 32'(active && m_legal(cur_width, cur_addr)), 32'd1);
        chk("wb_adr", wb_adr_o, cur_addr & 32'hFFFF_FFFC);
        chk("wb_sel", 32'(wb_sel_o), 32'(m_sel(cur_width, cur_addr)));
        chk("wb_we", 32'(wb_we_o), 32'(cur_cmd));
        if (cur_cmd) chk("wb_dat_o", wb_dat_o, m_dat(cur_width, cur_wdata));
      end
      if (dmem_resp) begin
        snap_rdata = dmem_rdata;
        snap_err   = dmem_err;
        chk("resp_expected", 32'(active), 32'd1);
        chk("dmem_err", 32'(dmem_err), 32'(cur_err));
        chk("dmem_rdata", dmem_rdata,
            (cur_err || cur_cmd) ? 32'h0 : m_rdata(cur_width, cur_addr, cur_rd));
      end
    end
  end

  // One core transaction. ack_wait = wait states before ack (<0: never ack).
  // Starts just after a rising edge; ends just after the edge following resp.
  task automatic run_txn(input string tag, input logic cmd, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_wait, input bit keep);
    int  exp_lat, exp_cyc, lat, ncyc;
    bit  legal, tmo, done;
    legal   = m_legal(w, a);
    tmo     = legal && (ack_wait < 0 || ack_wait >= TO);
    exp_cyc = !legal ? 0 : (tmo ? TO : ack_wait + 1);
    exp_lat = !legal ? 1 : exp_cyc + 1;
    cur_cmd = cmd; cur_width = w; cur_addr = a; cur_wdata = wd; cur_rd = rd;
    cur_err = !legal || tmo;
    active  = 1'b1;
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = wd;
    wb_dat_i = ~rd;
    ncyc = 0; lat = -1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = ~rd;
      if (dmem_resp) begin
        lat  = i;
        done = 1'b1;
      end else if (wb_cyc_o) begin
        ncyc++;
        if (ncyc == ack_wait + 1) begin
          wb_ack_i = 1'b1;
          wb_dat_i = rd;
        end
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_cyc_cycles"}, 32'(ncyc), 32'(exp_cyc));
    @(posedge clk);
    #1;
    active = 1'b0;
    if (!keep) dmem_req = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_rdata", dmem_rdata, 32'd0);
    chk("rst_resp", 32'(dmem_resp), 32'd0);
    chk("rst_err", 32'(dmem_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word read, two wait states.
    run_txn("t1_word_rd", 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    chk("pin_t1_rdata", snap_rdata, 32'hDEAD_BEEF);
    chk("pin_t1_err", 32'(snap_err), 32'd0);

    // Byte write to lane 3.
    run_txn("t2_byte_wr", 1'b1, 2'b00, 32'h203, 32'h0000_00A5, 32'h0, 0, 1'b0);
    chk("pin_t2_adr", snap_adr, 32'h200);
    chk("pin_t2_sel", 32'(snap_sel), 32'h8);
    chk("pin_t2_dat", snap_dat, 32'hA5A5_A5A5);
    chk("pin_t2_we", 32'(snap_we), 32'd1);

    // Halfword read of the upper half.
    run_txn("t2_half_rd", 1'b0, 2'b01, 32'h202, 32'h0, 32'h1234_ABCD, 1, 1'b0);
    chk("pin_t2_half_rdata", snap_rdata, 32'h0000_1234);

    // Further lane patterns.
    run_txn("byte_rd_o1", 1'b0, 2'b00, 32'h101, 32'h0, 32'h1122_3344, 0, 1'b0);
    run_txn("half_wr_o0", 1'b1, 2'b01, 32'h400, 32'h0000_BEEF, 32'h0, 0, 1'b0);
    run_txn("word_wr", 1'b1, 2'b10, 32'h404, 32'hCAFE_F00D, 32'h0, 3, 1'b0);

    // Illegal requests.
    run_txn("t3_word_mis", 1'b0, 2'b10, 32'h101, 32'h0, 32'h5555_5555, 0, 1'b0);
    chk("pin_t3_err", 32'(snap_err), 32'd1);
    chk("pin_t3_rdata", snap_rdata, 32'h0);
    run_txn("t3_rsvd", 1'b0, 2'b11, 32'h100, 32'h0, 32'h5555_5555, 0, 1'b0);
    run_txn("half_mis", 1'b1, 2'b01, 32'h203, 32'h1234, 32'h0, 0, 1'b0);

    // Timeout, then ack in the last permitted cycle.
    run_txn("t4_timeout", 1'b0, 2'b10, 32'h500, 32'h0, 32'h7777_7777, -1, 1'b0);
    chk("pin_t4_err", 32'(snap_err), 32'd1);
    run_txn("t4_ack_last", 1'b0, 2'b10, 32'h504, 32'h0, 32'h8888_0001, 3, 1'b0);
    chk("pin_t4_ack_err", 32'(snap_err), 32'd0);

    // Back-to-back reads.
    run_txn("t5_b2b_0", 1'b0, 2'b10, 32'h600, 32'h0, 32'hA000_0001, 0, 1'b1);
    run_txn("t5_b2b_1", 1'b0, 2'b00, 32'h602, 32'h0, 32'hA0B1_C2D3, 1, 1'b1);
    run_txn("t5_b2b_2", 1'b0, 2'b01, 32'h604, 32'h0, 32'h1357_9BDF, 0, 1'b0);

    // Reset while the bus cycle is open.
    cur_cmd = 1'b0; cur_width = 2'b10; cur_addr = 32'h700; cur_err = 1'b0; active = 1'b1;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    chk("t6_cyc_before_rst", 32'(wb_cyc_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_cyc_in_rst", 32'(wb_cyc_o), 32'd0);
    chk("t6_stb_in_rst", 32'(wb_stb_o), 32'd0);
    chk("t6_resp_in_rst", 32'(dmem_resp), 32'd0);
    dmem_req = 1'b0;
    active = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_resp_after_rst", 32'(dmem_resp), 32'd0);
    end
    @(posedge clk); #1;
    run_txn("t6_after_rst", 1'b0, 2'b10, 32'h704, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    chk("pin_t6_rdata", snap_rdata, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
